fetch_unit: RTL and testbench

- Parametrised successor to the single-cycle PC/adder/branch-mux front end.
- Owns the program counter and issues sequential fetches to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions with their PCs in a DEPTH-entry queue and hands them to decode over a valid/ready handshake.
- Accepts a redirect (taken branch/jump) that flushes all buffered and in-flight work.

---
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, sequential fetch from a 1-cycle sync imem,
// DEPTH-entry {pc,instr} queue to decode over valid/ready, redirect flush.
// Ports:
//   clock, reset              : clock, synchronous active-high reset
//   imem_en, imem_addr        : fetch request and address
//   imem_rdata                : instruction, one cycle after imem_en
//   redirect_valid/pc         : new PC, flushes queue and in-flight fetch
//   out_valid/ready/pc/instr  : head of fetch queue to decode
//   count                     : entries currently queued
module fetch_unit #(
  parameter int XLEN = 64,
  parameter int IW = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       imem_en,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [IW-1:0]              imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [IW-1:0]              out_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [XLEN-1:0] q_pc [DEPTH];
  logic [IW-1:0]   q_instr [DEPTH];

  logic [CW:0]     used;
  logic            push;
  logic            pop;
  logic            unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];

  // Queued plus outstanding entries; a request is only
  // issued when its response is guaranteed a slot.
  assign used = {1'b0, count} + {{CW{1'b0}}, inflight};

  assign imem_en = !reset && !redirect_valid && (used < DEPTH_W);
  assign imem_addr = fetch_pc;

  assign push = inflight && !redirect_valid && !reset;
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop = out_valid && out_ready;

  assign out_pc = q_pc[rd_ptr];
  assign out_instr = q_instr[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        inflight_pc <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; entries are only read when counted.
  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr] <= inflight_pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random stimulus against a queue-based
// model of the fetch front end, imem modelled as addr->instr hash.
module tb_fetch_unit;

  localparam int XLEN = 64;
  localparam int IW = 32;
  localparam int DEPTH = 4;
  localparam logic [63:0] RST_PC = 64'h0;

  logic            clock = 1'b0;
  logic            reset;
  logic            imem_en;
  logic [63:0]     imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [63:0]     redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_pc;
  logic [31:0]     out_instr;
  logic [2:0]      count;

  fetch_unit #(
    .XLEN(XLEN), .IW(IW), .DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .count(count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference model state: the spec's queue, PC and outstanding fetch.
  logic [63:0] mq[$];
  logic [63:0] m_pc;
  logic        m_inf;
  logic [63:0] m_inf_pc;
  bit          checking = 0;

  logic        last_en;
  logic [63:0] last_addr;
  logic        last_valid;
  logic [63:0] last_pc;
  logic [2:0]  last_count;

  function automatic logic [31:0] f(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic rv,
                     input logic [63:0] rpc, input logic rdy);
    logic e_en;
    logic e_valid;
    reset = rst;
    redirect_valid = rv;
    redirect_pc = rpc;
    out_ready = rdy;
    #1;
    e_en = !rst && !rv && (mq.size() + int'(m_inf) < DEPTH);
    e_valid = (mq.size() != 0) && !rv;
    if (checking) begin
      chk("imem_en", 64'(imem_en), 64'(e_en));
      if (e_en) chk("imem_addr", imem_addr, m_pc);
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(e_valid));
      chk("no_overflow", 64'(count <= 3'(DEPTH)), 64'd1);
      if (e_valid) begin
        chk("out_pc", out_pc, mq[0]);
        chk("out_instr", 64'(out_instr), 64'(f(mq[0])));
      end
    end
    last_en = imem_en;
    last_addr = imem_addr;
    last_valid = out_valid;
    last_pc = out_pc;
    last_count = count;
    if (rst) begin
      mq.delete();
      m_pc = RST_PC;
      m_inf = 1'b0;
    end else if (rv) begin
      mq.delete();
      m_pc = {rpc[63:2], 2'b00};
      m_inf = 1'b0;
    end else begin
      if (e_valid && rdy) void'(mq.pop_front());
      if (m_inf) mq.push_back(m_inf_pc);
      m_inf = e_en;
      if (e_en) begin
        m_inf_pc = m_pc;
        m_pc = m_pc + 64'd4;
      end
    end
    @(posedge clock);
    #1;
    imem_rdata = last_en ? f(last_addr) : $urandom;
    checking = 1;
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    imem_rdata = '0;
    m_pc = RST_PC;
    m_inf = 1'b0;
    m_inf_pc = '0;
    @(posedge clock);
    #1;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset_valid", 64'(last_valid), 64'd0);
    chk("reset_en", 64'(last_en), 64'd0);

    cyc(0, 0, 0, 1);
    chk("first_addr", last_addr, 64'h0);
    cyc(0, 0, 0, 1);
    chk("second_addr", last_addr, 64'h4);
    cyc(0, 0, 0, 1);
    chk("first_out", 64'(last_valid), 64'd1);
    chk("first_out_pc", last_pc, 64'h0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
    chk("bp_count", 64'(last_count), 64'd4);
    chk("bp_en", 64'(last_en), 64'd0);
    cyc(0, 0, 0, 1);
    chk("bp_pop_pc", last_pc, 64'h0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);

    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 64'h100, 1);
    cyc(0, 0, 0, 1);
    chk("rd_count", 64'(last_count), 64'd0);
    chk("rd_addr", last_addr, 64'h100);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rd_out_pc", last_pc, 64'h100);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
    chk("full_count", 64'(last_count), 64'd4);
    cyc(0, 1, 64'h203, 1);
    chk("full_rd_valid", 64'(last_valid), 64'd0);
    cyc(0, 0, 0, 1);
    chk("full_rd_count", 64'(last_count), 64'd0);
    chk("full_rd_addr", last_addr, 64'h200);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);

    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("mid_rst_valid", 64'(last_valid), 64'd0);
    chk("mid_rst_count", 64'(last_count), 64'd0);
    chk("mid_rst_addr", last_addr, RST_PC);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);

    cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("wrap_addr", last_addr, 64'h0);
    cyc(0, 0, 0, 1);
    chk("wrap_pc0", last_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(0, 0, 0, 1);
    chk("wrap_pc1", last_pc, 64'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      logic r;
      logic rv;
      logic [63:0] rpc;
      r = ($urandom_range(99) == 0);
      rv = ($urandom_range(99) < 6);
      if ($urandom_range(3) == 0)
        rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
      else
        rpc = {32'($urandom), 32'($urandom)};
      cyc(r, rv, rpc, 1'($urandom_range(2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
